// File: rtl/cube_root_pkg.sv
// rtl/cube_root_pkg.sv - shared types and width helpers for the cube root unit
package cube_root_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Root width needed to hold floor(cbrt(x)) for any w-bit x.
  function automatic int rwidth_of(input int w);
    return (w + 2) / 3;
  endfunction

  // Width of the bit-index counter that walks the root bits.
  function automatic int bwidth_of(input int rw);
    return (rw > 1) ? $clog2(rw) : 1;
  endfunction

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_RWIDTH = rwidth_of(DEF_WIDTH);
  // Trial cubes are compared at full precision so they can never wrap.
  localparam int DEF_PWIDTH = 3 * DEF_RWIDTH;

endpackage

// File: rtl/cube_root_trial.sv
// rtl/cube_root_trial.sv - one restoring step: try the next root bit and keep it if the cube fits
module cube_root_trial
  import cube_root_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int RWIDTH = rwidth_of(WIDTH),
  parameter int BWIDTH = bwidth_of(RWIDTH)
) (
  input  logic [RWIDTH-1:0] r,
  input  logic [BWIDTH-1:0] b,
  input  logic [WIDTH-1:0]  operand,
  output logic              accept,
  output logic [RWIDTH-1:0] next_r
);

  localparam int PWIDTH = 3 * RWIDTH;

  logic [RWIDTH-1:0] one;
  logic [RWIDTH-1:0] t;
  logic [PWIDTH-1:0] t_ext;
  logic [PWIDTH-1:0] t_cube;

  assign one    = RWIDTH'(1);
  assign t      = r | (one << b);
  assign t_ext  = PWIDTH'(t);
  // Full-width cube: the largest trial (all ones) still fits in 3*RWIDTH bits.
  assign t_cube = t_ext * t_ext * t_ext;
  assign accept = (t_cube <= PWIDTH'(operand));
  assign next_r = accept ? t : r;

endmodule

// File: rtl/cube_root.sv
// rtl/cube_root.sv - bit-serial integer cube root with remainder, one root bit per cycle
module cube_root
  import cube_root_pkg::*;
#(
  parameter  int WIDTH  = DEF_WIDTH,
  localparam int RWIDTH = rwidth_of(WIDTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  num,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RWIDTH-1:0] root,
  output logic [WIDTH-1:0]  rem
);

  localparam int BWIDTH = bwidth_of(RWIDTH);
  localparam logic [BWIDTH-1:0] BTOP = BWIDTH'(RWIDTH - 1);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  operand_q;
  logic [BWIDTH-1:0] bit_q;
  logic [RWIDTH-1:0] r_q;
  logic [RWIDTH-1:0] root_q;
  logic [WIDTH-1:0]  rem_q;

  logic              accept;
  logic [RWIDTH-1:0] next_r;
  logic [WIDTH-1:0]  nr_ext;
  logic [WIDTH-1:0]  nr_cube;

  cube_root_trial #(
    .WIDTH  (WIDTH),
    .RWIDTH (RWIDTH),
    .BWIDTH (BWIDTH)
  ) u_trial (
    .r       (r_q),
    .b       (bit_q),
    .operand (operand_q),
    .accept  (accept),
    .next_r  (next_r)
  );

  // The final root's cube never exceeds the operand, so WIDTH-bit arithmetic is exact here.
  assign nr_ext  = WIDTH'(next_r);
  assign nr_cube = nr_ext * nr_ext * nr_ext;

  assign root = root_q;
  assign rem  = rem_q;

  // State and datapath registers; reset aborts any computation in flight.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= IDLE;
      operand_q <= '0;
      bit_q     <= '0;
      r_q       <= '0;
      root_q    <= '0;
      rem_q     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            operand_q <= num;
            r_q       <= '0;
            bit_q     <= BTOP;
          end
        end
        CALC: begin
          if (accept) begin
            r_q <= next_r;
          end
          if (bit_q == '0) begin
            root_q <= next_r;
            rem_q  <= operand_q - nr_cube;
          end else begin
            bit_q <= bit_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = CALC;
        end
      end
      CALC: begin
        if (bit_q == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cube_root.sv
// tb/tb_cube_root.sv - directed and round-trip checks for cube_root
module tb_cube_root;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] num = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [10:0] root;
  logic [31:0] rem;

  int n_vec = 0;
  int n_err = 0;

  cube_root #(.WIDTH(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .num       (num),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .root      (root),
    .rem       (rem)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are read there too.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Run one operand; lat counts rising edges from the accept edge (inclusive) to out_valid.
  task automatic op(input logic [31:0] n, input int hold,
                    output logic [10:0] r, output logic [31:0] m, output int lat);
    logic [10:0] r0;
    logic [31:0] m0;
    if (in_ready !== 1'b1) chk("in_ready_before_op", longint'(in_ready), 1);
    in_valid = 1'b1;
    num      = n;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    if (out_valid !== 1'b1) chk("out_valid_timeout", longint'(out_valid), 1);
    r = root;
    m = rem;
    r0 = root;
    m0 = rem;
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("bp_out_valid", longint'(out_valid), 1);
      chk("bp_in_ready", longint'(in_ready), 0);
      chk("bp_root", longint'(root), longint'(r0));
      chk("bp_rem", longint'(rem), longint'(m0));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    if (hold > 0) begin
      chk("release_out_valid", longint'(out_valid), 0);
      chk("release_in_ready", longint'(in_ready), 1);
    end
  endtask

  typedef struct {
    logic [31:0] n;
    logic [10:0] r;
    logic [31:0] m;
  } vec_t;

  vec_t vecs[$] = '{
    '{32'd26,         11'd2,    32'd18},
    '{32'd999999,     11'd99,   32'd29700},
    '{32'd1000000,    11'd100,  32'd0},
    '{32'd0,          11'd0,    32'd0},
    '{32'hFFFFFFFF,   11'd1625, 32'd3951670},
    '{32'd4291015625, 11'd1625, 32'd0}
  };

  initial begin
    logic [10:0] r;
    logic [31:0] m;
    int lat;
    longint rr, nn;

    // Reset state
    repeat (3) tick();
    chk("rst_in_ready", longint'(in_ready), 1);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_root", longint'(root), 0);
    chk("rst_rem", longint'(rem), 0);
    reset = 1'b1;
    tick();

    // Exact cube and latency
    op(32'd27, 0, r, m, lat);
    chk("c27_root", longint'(r), 3);
    chk("c27_rem", longint'(m), 0);
    chk("c27_latency", longint'(lat), 12);

    // Directed vectors and boundaries
    foreach (vecs[i]) begin
      op(vecs[i].n, 0, r, m, lat);
      chk($sformatf("vec%0d_root", i), longint'(r), longint'(vecs[i].r));
      chk($sformatf("vec%0d_rem", i), longint'(m), longint'(vecs[i].m));
    end

    // Backpressure: result held for 5 cycles
    op(32'd64, 5, r, m, lat);
    chk("bp64_root", longint'(r), 4);
    chk("bp64_rem", longint'(m), 0);

    // Reset in CALC cycle 4 aborts the operation
    in_valid = 1'b1;
    num      = 32'd8;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("abort_out_valid", longint'(out_valid), 0);
    chk("abort_root", longint'(root), 0);
    chk("abort_rem", longint'(rem), 0);
    chk("abort_in_ready", longint'(in_ready), 1);
    repeat (15) tick();
    chk("abort_no_result", longint'(out_valid), 0);
    op(32'd125, 0, r, m, lat);
    chk("post_abort_root", longint'(r), 5);
    chk("post_abort_rem", longint'(m), 0);

    // Round trip: every cube n^3 for n in 0..1625
    for (int n = 0; n <= 1625; n++) begin
      nn = longint'(n) * n * n;
      op(nn[31:0], 0, r, m, lat);
      chk($sformatf("rt%0d_root", n), longint'(r), longint'(n));
      chk($sformatf("rt%0d_rem", n), longint'(m), 0);
    end

    // Random operands checked against the defining inequality
    for (int k = 0; k < 3000; k++) begin
      logic [31:0] x;
      x = $urandom;
      op(x, 0, r, m, lat);
      rr = longint'(r);
      nn = longint'(x);
      chk("rand_lo", longint'(rr * rr * rr <= nn), 1);
      chk("rand_hi", longint'((rr + 1) * (rr + 1) * (rr + 1) > nn), 1);
      chk("rand_rem", longint'(m), nn - rr * rr * rr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
